// File: rtl/mux_rr_arbiter_if.sv
// Handshake bundle between two requesters, the arbiter and the downstream
// consumer of the shared registered output.
interface mux_rr_arbiter_if #(
  parameter int WIDTH = 4
);
  logic             a_valid;
  logic [WIDTH-1:0] a_data;
  logic             a_ready;
  logic             b_valid;
  logic [WIDTH-1:0] b_data;
  logic             b_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic             select;
  logic             busy;

  // Arbiter side: takes requests and downstream ready, drives the rest.
  modport slave (
    input  a_valid, a_data, b_valid, b_data, out_ready,
    output a_ready, b_ready, out_valid, out_data, select, busy
  );

  // Environment side: requesters plus downstream consumer.
  modport master (
    output a_valid, a_data, b_valid, b_data, out_ready,
    input  a_ready, b_ready, out_valid, out_data, select, busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for two handshaked requesters sharing one registered
// output slot. A burst limit forces a hand-over when the other side waits.
module mux_rr_arbiter #(
  parameter int WIDTH     = 4,
  parameter int MAX_BURST = 4
) (
  input  logic           clk,
  input  logic           rstN,   // active-high despite the name
  mux_rr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_A = 2'd1,
    SERVE_B = 2'd2
  } state_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);
  localparam logic       GRANT_A     = 1'b0;
  localparam logic       GRANT_B     = 1'b1;

  state_t           state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic             select_q, select_d;
  logic             last_grant_q, last_grant_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;

  logic             slot_free;
  logic             a_ready, b_ready;
  logic             a_accept, b_accept, accept;
  logic [3:0]       burst_inc;
  logic             own_valid, other_valid;
  logic             grant_req, grant_to, other_side;

  // The slot can take a word when it is empty or being drained this cycle.
  assign slot_free = !out_valid_q || bus.out_ready;
  assign a_ready   = (state_q == SERVE_A) && slot_free;
  assign b_ready   = (state_q == SERVE_B) && slot_free;
  assign a_accept  = bus.a_valid && a_ready;
  assign b_accept  = bus.b_valid && b_ready;
  assign accept    = a_accept || b_accept;

  // Saturating count of the accept happening this cycle.
  assign burst_inc = (burst_cnt_q >= BURST_LIMIT) ? BURST_LIMIT : burst_cnt_q + 4'd1;

  // Output slot: load on accept, otherwise empty it once consumed.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (a_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.a_data;
    end else if (b_accept) begin
      out_valid_d = 1'b1;
      out_data_d  = bus.b_data;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Grant sequencing: idle arbitration, early yield and burst hand-over.
  always_comb begin
    state_d      = state_q;
    select_d     = select_q;
    last_grant_d = last_grant_q;
    burst_cnt_d  = burst_cnt_q;
    grant_req    = 1'b0;
    grant_to     = GRANT_A;
    own_valid    = (state_q == SERVE_B) ? bus.b_valid : bus.a_valid;
    other_valid  = (state_q == SERVE_B) ? bus.a_valid : bus.b_valid;
    other_side   = (state_q == SERVE_B) ? GRANT_A : GRANT_B;

    case (state_q)
      IDLE: begin
        if (bus.a_valid && bus.b_valid) begin
          grant_req = 1'b1;
          grant_to  = ~last_grant_q;
        end else if (bus.a_valid) begin
          grant_req = 1'b1;
          grant_to  = GRANT_A;
        end else if (bus.b_valid) begin
          grant_req = 1'b1;
          grant_to  = GRANT_B;
        end
      end
      SERVE_A, SERVE_B: begin
        if (!own_valid) begin
          // Owner has nothing: hand over directly, or fall back to idle.
          if (other_valid) begin
            grant_req = 1'b1;
            grant_to  = other_side;
          end else begin
            state_d = IDLE;
          end
        end else if (accept) begin
          if (burst_inc >= BURST_LIMIT) begin
            if (other_valid) begin
              grant_req = 1'b1;
              grant_to  = other_side;
            end else begin
              burst_cnt_d = 4'd0;  // nobody waiting: start a fresh burst
            end
          end else begin
            burst_cnt_d = burst_inc;
          end
        end
        // Stalled cycles leave everything unchanged.
      end
      default: state_d = IDLE;
    endcase

    if (grant_req) begin
      state_d      = (grant_to == GRANT_B) ? SERVE_B : SERVE_A;
      select_d     = grant_to;
      last_grant_d = grant_to;
      burst_cnt_d  = 4'd0;
    end
  end

  // State and output registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rstN) begin
      state_q      <= IDLE;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      select_q     <= GRANT_A;
      last_grant_q <= GRANT_B;
      burst_cnt_q  <= 4'd0;
    end else begin
      state_q      <= state_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      select_q     <= select_d;
      last_grant_q <= last_grant_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

  assign bus.a_ready   = a_ready;
  assign bus.b_ready   = b_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.select    = select_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
